// File: rtl/fp_add_pkg.sv
// Shared widths and record types for the FP adder alignment front end.
package fp_add_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int EXPO_W_DEF = 8;
  localparam int MENT_W_DEF = 23;
  localparam int GRS_W      = 3;

  typedef struct packed {
    logic sign;
    logic eff_sub;
    logic special;
  } align_flags_t;

  typedef struct packed {
    logic                         sign;
    logic                         eff_sub;
    logic                         special;
    logic [EXPO_W_DEF-1:0]        big_exp;
    logic [MENT_W_DEF:0]          big_mant;
    logic [MENT_W_DEF+GRS_W:0]    small_mant;
  } align_rec_t;

endpackage

// File: rtl/fp_add_align_shifter.sv
// Right shift of the smaller mantissa into a guard/round/sticky-extended
// field; every bit shifted out is folded into the LSB.
module fp_align_shifter
  import fp_add_pkg::*;
#(
  parameter int MANT_W  = MENT_W_DEF + 1,
  parameter int SHAMT_W = EXPO_W_DEF + 1
) (
  input  logic [MANT_W-1:0]       mant_in,
  input  logic [SHAMT_W-1:0]      shamt_in,
  output logic [MANT_W+GRS_W-1:0] mant_out
);
  localparam int OUT_W = MANT_W + GRS_W;

  logic [OUT_W-1:0] ext;
  logic [OUT_W-1:0] shifted;
  logic [OUT_W-1:0] lost_mask;
  logic             sticky;
  logic             full_out;

  assign ext       = {mant_in, {GRS_W{1'b0}}};
  assign full_out  = (32'(shamt_in) >= OUT_W);
  assign shifted   = ext >> shamt_in;
  assign lost_mask = ~({OUT_W{1'b1}} << shamt_in);
  assign sticky    = |(ext & lost_mask);

  always_comb begin
    mant_out = {shifted[OUT_W-1:1], shifted[0] | sticky};
    // Everything falls off the end: only the sticky summary survives.
    if (full_out) mant_out = {{(OUT_W-1){1'b0}}, |ext};
  end

endmodule

// File: rtl/fp_add_align_pipe.sv
// Two-stage operand swap/alignment pipeline for an FP adder with valid/ready.
// Define FP_ALIGN_SPECIAL_EN to flag all-ones exponents on special_out.
module fp_add_align_pipe
  import fp_add_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int EXPO_WIDTH = EXPO_W_DEF,
  parameter int MENT_WIDTH = MENT_W_DEF
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        valid_in,
  output logic                        ready_in,
  input  logic [DATA_WIDTH-1:0]       floating1_in,
  input  logic [DATA_WIDTH-1:0]       floating2_in,
  input  logic                        op_sub_in,
  output logic                        valid_out,
  input  logic                        ready_out,
  output logic [MENT_WIDTH:0]         big_mant_out,
  output logic [MENT_WIDTH+GRS_W:0]   small_mant_out,
  output logic [EXPO_WIDTH-1:0]       big_exp_out,
  output logic                        sign_out,
  output logic                        eff_sub_out,
  output logic                        special_out
);
  localparam int SM_W = MENT_WIDTH + 1 + GRS_W;

  logic s1_full_q, s1_full_d, s2_full_q, s2_full_d;
  logic in_fire, s1_adv, s2_free;

  assign s2_free   = !s2_full_q || ready_out;
  assign s1_adv    = s1_full_q && s2_free;
  assign ready_in  = !rst_in && (!s1_full_q || s1_adv);
  assign in_fire   = valid_in && ready_in;
  assign s1_full_d = in_fire || (s1_full_q && !s1_adv);
  assign s2_full_d = s1_adv || (s2_full_q && !ready_out);

  logic                  sign_a, sign_b;
  logic [EXPO_WIDTH-1:0] exp_a, exp_b, eexp_a, eexp_b;
  logic [MENT_WIDTH-1:0] frac_a, frac_b;
  logic [MENT_WIDTH:0]   mant_a, mant_b;
  logic [EXPO_WIDTH:0]   diff_raw, diff_neg;
  logic                  a_big;
  logic                  special_in;

  assign {sign_a, exp_a, frac_a} = floating1_in;
  assign {sign_b, exp_b, frac_b} = floating2_in;

  assign eexp_a = (exp_a == '0) ? EXPO_WIDTH'(1) : exp_a;
  assign eexp_b = (exp_b == '0) ? EXPO_WIDTH'(1) : exp_b;
  assign mant_a = {(exp_a != '0), frac_a};
  assign mant_b = {(exp_b != '0), frac_b};

  assign diff_raw = {1'b0, eexp_a} - {1'b0, eexp_b};
  assign diff_neg = {1'b0, eexp_b} - {1'b0, eexp_a};
  // Equal exponents compare with the hidden bit so a subnormal never beats exp=1.
  assign a_big = !diff_raw[EXPO_WIDTH] && ((diff_raw != '0) || (mant_a >= mant_b));

`ifdef FP_ALIGN_SPECIAL_EN
  assign special_in = (&exp_a) || (&exp_b);
`else
  assign special_in = 1'b0;
`endif

  logic [MENT_WIDTH:0]   s1_big_mant_q, s1_big_mant_d;
  logic [MENT_WIDTH:0]   s1_small_mant_q, s1_small_mant_d;
  logic [EXPO_WIDTH-1:0] s1_big_exp_q, s1_big_exp_d;
  logic [EXPO_WIDTH:0]   s1_shamt_q, s1_shamt_d;
  align_flags_t          s1_flags_q, s1_flags_d;

  logic [MENT_WIDTH:0]   s2_big_mant_q, s2_big_mant_d;
  logic [SM_W-1:0]       s2_small_mant_q, s2_small_mant_d;
  logic [EXPO_WIDTH-1:0] s2_big_exp_q, s2_big_exp_d;
  align_flags_t          s2_flags_q, s2_flags_d;

  logic [SM_W-1:0]       aligned_small;

  fp_align_shifter #(
    .MANT_W  (MENT_WIDTH + 1),
    .SHAMT_W (EXPO_WIDTH + 1)
  ) u_shifter (
    .mant_in  (s1_small_mant_q),
    .shamt_in (s1_shamt_q),
    .mant_out (aligned_small)
  );

  always_comb begin
    s1_big_mant_d   = s1_big_mant_q;
    s1_small_mant_d = s1_small_mant_q;
    s1_big_exp_d    = s1_big_exp_q;
    s1_shamt_d      = s1_shamt_q;
    s1_flags_d      = s1_flags_q;
    s2_big_mant_d   = s2_big_mant_q;
    s2_small_mant_d = s2_small_mant_q;
    s2_big_exp_d    = s2_big_exp_q;
    s2_flags_d      = s2_flags_q;
    if (in_fire) begin
      s1_big_mant_d      = a_big ? mant_a : mant_b;
      s1_small_mant_d    = a_big ? mant_b : mant_a;
      s1_big_exp_d       = a_big ? eexp_a : eexp_b;
      s1_shamt_d         = a_big ? diff_raw : diff_neg;
      s1_flags_d.sign    = a_big ? sign_a : (sign_b ^ op_sub_in);
      s1_flags_d.eff_sub = sign_a ^ sign_b ^ op_sub_in;
      s1_flags_d.special = special_in;
    end
    if (s1_adv) begin
      s2_big_mant_d   = s1_big_mant_q;
      s2_small_mant_d = aligned_small;
      s2_big_exp_d    = s1_big_exp_q;
      s2_flags_d      = s1_flags_q;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_full_q       <= 1'b0;
      s2_full_q       <= 1'b0;
      s1_big_mant_q   <= '0;
      s1_small_mant_q <= '0;
      s1_big_exp_q    <= '0;
      s1_shamt_q      <= '0;
      s1_flags_q      <= '0;
      s2_big_mant_q   <= '0;
      s2_small_mant_q <= '0;
      s2_big_exp_q    <= '0;
      s2_flags_q      <= '0;
    end else begin
      s1_full_q       <= s1_full_d;
      s2_full_q       <= s2_full_d;
      s1_big_mant_q   <= s1_big_mant_d;
      s1_small_mant_q <= s1_small_mant_d;
      s1_big_exp_q    <= s1_big_exp_d;
      s1_shamt_q      <= s1_shamt_d;
      s1_flags_q      <= s1_flags_d;
      s2_big_mant_q   <= s2_big_mant_d;
      s2_small_mant_q <= s2_small_mant_d;
      s2_big_exp_q    <= s2_big_exp_d;
      s2_flags_q      <= s2_flags_d;
    end
  end

  assign valid_out      = s2_full_q;
  assign big_mant_out   = s2_big_mant_q;
  assign small_mant_out = s2_small_mant_q;
  assign big_exp_out    = s2_big_exp_q;
  assign sign_out       = s2_flags_q.sign;
  assign eff_sub_out    = s2_flags_q.eff_sub;
  assign special_out    = s2_flags_q.special;

endmodule

// File: doc/fp_add_align_pipe.md
FP_ADD_ALIGN_PIPE -- requirements
Module: fp_add_align_pipe

Interface
REQ-001 Parameter DATA_WIDTH, 32, total floating-point word width (sign+exponent+mantissa).
REQ-002 Parameter EXPO_WIDTH, 8, exponent field width.
REQ-003 Parameter MENT_WIDTH, 23, stored mantissa field width; DATA_WIDTH SHALL equal 1+EXPO_WIDTH+MENT_WIDTH.
REQ-004 Port clk_in  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_in  input  1  reset, asynchronous, active-high.
REQ-006 Port valid_in  input  1  operand pair present.
REQ-007 Port ready_in  output  1  block accepts operand pair this cycle.
REQ-008 Port floating1_in / floating2_in  input  DATA_WIDTH  operands A and B.
REQ-009 Port op_sub_in  input  1  1 = A-B, 0 = A+B.
REQ-010 Port valid_out  output  1  aligned result present.
REQ-011 Port ready_out  input  1  downstream (mantissa adder) accepts result.
REQ-012 Port big_mant_out  output  MENT_WIDTH+1  larger-magnitude mantissa with hidden bit.
REQ-013 Port small_mant_out  output  MENT_WIDTH+4  smaller mantissa with hidden bit, right-shifted, plus guard/round/sticky LSBs.
REQ-014 Port big_exp_out  output  EXPO_WIDTH  larger effective exponent.
REQ-015 Port sign_out  output  1  result sign (sign of larger-magnitude operand, B's sign inverted when op_sub_in=1).
REQ-016 Port eff_sub_out  output  1  1 when effective operation is magnitude subtraction.
REQ-017 Port special_out  output  1  NaN/Inf operand detected (see REQ-031).

Function
REQ-018 Transfer in SHALL occur when valid_in && ready_in; transfer out when valid_out && ready_out.
REQ-019 Two register stages (S1, S2); latency SHALL be exactly 2 cycles with ready_out held high; throughput 1 pair/cycle.
REQ-020 Each stage SHALL load when empty or when its contents advance in the same cycle; ready_in = !S1_full || S1 advances (combinational, no bubble).
REQ-021 With valid_out=1 and ready_out=0, all outputs SHALL hold stable; up to 2 transactions SHALL be retained without loss or reordering.
REQ-022 S1: unpack; zero exponent field SHALL give hidden bit 0 and effective exponent 1 (subnormal), else hidden bit 1.
REQ-023 S1: exponent difference computed on EXPO_WIDTH+1 bits by two's-complement subtraction; sign bit selects larger exponent.
REQ-024 S1: on equal exponents, larger stored mantissa SHALL be "big"; on full magnitude tie, A SHALL be "big".
REQ-025 eff_sub = signA XOR signB XOR op_sub_in; sign_out per REQ-015.
REQ-026 S2: small mantissa extended with 3 zero LSBs then shifted right by the difference; sticky (LSB) SHALL be OR of all bits shifted out.
REQ-027 Shift >= MENT_WIDTH+4 SHALL produce zero mantissa with sticky = OR of entire pre-shift value.
REQ-028 Data outputs SHALL be driven only from S2 registers (no combinational input-to-output path).

Reset
REQ-029 While rst_in=1: valid_out=0, ready_in=0, all data outputs and stage registers 0, both stages empty.
REQ-030 Reset asserted mid-operation SHALL discard in-flight transactions immediately; first cycle after release ready_in=1.

Configuration
REQ-031 Macro FP_ALIGN_SPECIAL_EN defined: all-ones exponent on either operand sets special_out=1 for that transaction (alignment fields still computed); undefined: special_out tied 0, all-ones exponents treated as normal numbers.

Structure
REQ-032 Package fp_add_pkg SHALL hold default width constants, GRS width (3) and the aligned-operand record typedef.
REQ-033 Sub-module fp_align_shifter SHALL implement the sticky-preserving right shift of REQ-026/027.

Verification
REQ-034 A=0x3F800000, B=0x3F000000, add -> big_exp 0x7F, big_mant 0x800000, small_mant 0x2000000, sign 0, eff_sub 0, 2 cycles later.
REQ-035 A=0x3F000000, B=0xC0000000, add -> swap: big_exp 0x80, small_mant 0x1000000, sign 1, eff_sub 1.
REQ-036 A=0x3F800000, B=0x30800000 (diff 30) -> small_mant 0x0000001 (sticky only).
REQ-037 A=0x3FC00000, B=0xBFA00000, add -> big_mant 0xC00000, small_mant 0x5000000, sign 0, eff_sub 1.
REQ-038 Back-to-back 3 pairs, ready_out low 3 cycles -> ready_in drops, outputs stable, all 3 delivered in order; rst_in pulse mid-stream -> valid_out 0 immediately, nothing delivered afterwards.
REQ-039 With FP_ALIGN_SPECIAL_EN, A=0x7F800000 -> special_out=1; without it, special_out=0.
